// File: rtl/s27_bist_pkg.sv
// Shared encodings, widths and polynomial helpers for the s27 scan/BIST controller.
package s27_bist_pkg;

  localparam int unsigned SCAN_LEN  = 3;
  localparam int unsigned PI_W      = 4;
  localparam int unsigned LFSR_W    = 7;
  localparam int unsigned MISR_W    = 8;
  localparam int unsigned CNT_W     = 8;
  localparam int unsigned BIT_CNT_W = 2;
  localparam int unsigned STATE_W   = 3;

  // Feedback taps x^7+x^6+1 and MISR reduction x^8+x^4+x^3+x^2+1.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 7'h60;
  localparam logic [MISR_W-1:0] MISR_POLY = 8'h1D;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t IDLE    = 3'd0;
  localparam state_t SEED    = 3'd1;
  localparam state_t SHIFT   = 3'd2;
  localparam state_t CAPTURE = 3'd3;
  localparam state_t FLUSH   = 3'd4;
  localparam state_t DONE    = 3'd5;

  // Fibonacci step: shift left, parity of the tapped bits enters at the lsb.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
    return {v[LFSR_W-2:0], ^(v & LFSR_TAPS)};
  endfunction

  // Internal-XOR step: shift left, fold the polynomial in when the msb falls out.
  function automatic logic [MISR_W-1:0] misr_step(input logic [MISR_W-1:0] v);
    return {v[MISR_W-2:0], 1'b0} ^ (v[MISR_W-1] ? MISR_POLY : '0);
  endfunction

endpackage

// File: rtl/s27_comb.sv
// Combinational core of the ISCAS89 s27 benchmark (flops live in the controller).
module s27_comb (
  input  logic [3:0] pi_i,          // {G3,G2,G1,G0}
  input  logic [2:0] state_i,       // {G5,G6,G7}
  output logic [2:0] next_state_o,  // {G10,G11,G13}
  output logic       g17_o
);

  logic g0, g1, g2, g3, g5, g6, g7;
  logic g8, g9, g10, g11, g12, g13, g14, g15, g16;

  assign g0  = pi_i[0];
  assign g1  = pi_i[1];
  assign g2  = pi_i[2];
  assign g3  = pi_i[3];
  assign g5  = state_i[2];
  assign g6  = state_i[1];
  assign g7  = state_i[0];

  assign g14 = ~g0;
  assign g8  = g14 & g6;
  assign g12 = ~(g1 | g7);
  assign g15 = g12 | g8;
  assign g16 = g3 | g8;
  assign g9  = ~(g16 & g15);
  assign g11 = ~(g5 | g9);
  assign g10 = ~(g14 | g11);
  assign g13 = ~(g2 | g12);

  assign next_state_o = {g10, g11, g13};
  assign g17_o        = ~g11;

endmodule

// File: rtl/s27_bist_ctrl.sv
// Scan/BIST controller: owns the s27 state flops and runs functional or LFSR/MISR self-test.
module s27_bist_ctrl
  import s27_bist_pkg::*;
#(
  parameter int unsigned        N_PATTERNS = 64,
  parameter logic [LFSR_W-1:0]  LFSR_SEED  = 7'h5A,
  parameter logic [MISR_W-1:0]  GOLDEN_SIG = 8'h00
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 func_en,
  input  logic [PI_W-1:0]      pi,
  output logic                 po,
  output logic [SCAN_LEN-1:0]  scan_state,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [MISR_W-1:0]    signature,
  output logic [CNT_W-1:0]     pattern_cnt
);

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [LFSR_W-1:0]    SEED_EFF = (LFSR_SEED == '0) ? LFSR_W'(1) : LFSR_SEED;
  localparam logic [CNT_W-1:0]     LAST_PAT = CNT_W'(N_PATTERNS - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(SCAN_LEN - 1);

  state_t                state_q, state_d;
  logic [SCAN_LEN-1:0]   flops_q, flops_d;
  logic [LFSR_W-1:0]     lfsr_q, lfsr_d;
  logic [MISR_W-1:0]     misr_q, misr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;

  logic seed_en, shift_en, capture_en, flush_en, func_load, pass_load, run_abort;
  logic [PI_W-1:0]     pi_core;
  logic [SCAN_LEN-1:0] core_nxt;
  logic                core_g17;
  logic                si, so;

  assign pi_core = busy_q ? lfsr_q[LFSR_W-1:LFSR_W-PI_W] : pi;
  assign si      = shift_en ? lfsr_q[0] : 1'b0;
  assign so      = flops_q[0];

  s27_comb u_core (
    .pi_i         (pi_core),
    .state_i      (flops_q),
    .next_state_o (core_nxt),
    .g17_o        (core_g17)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state; abort wins over everything while a run is active.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!abort && start) state_d = SEED;
      SEED:    state_d = abort ? IDLE : SHIFT;
      SHIFT:   if (abort) state_d = IDLE;
               else if (bit_cnt_q == LAST_BIT) state_d = CAPTURE;
      CAPTURE: if (abort) state_d = IDLE;
               else state_d = (cnt_q == LAST_PAT) ? FLUSH : SHIFT;
      FLUSH:   if (abort) state_d = IDLE;
               else if (bit_cnt_q == LAST_BIT) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: datapath enables from the current state, status flags from the next.
  always_comb begin
    seed_en    = 1'b0;
    shift_en   = 1'b0;
    capture_en = 1'b0;
    flush_en   = 1'b0;
    func_load  = 1'b0;
    run_abort  = 1'b0;
    case (state_q)
      IDLE:    func_load  = func_en && !start && !abort;
      SEED:    seed_en    = !abort;
      SHIFT:   shift_en   = !abort;
      CAPTURE: capture_en = !abort;
      FLUSH:   flush_en   = !abort;
      default: ;
    endcase
    if (state_q inside {SEED, SHIFT, CAPTURE, FLUSH}) run_abort = abort;
    busy_d    = state_d inside {SEED, SHIFT, CAPTURE, FLUSH};
    done_d    = (state_d == DONE);
    pass_load = (state_q == FLUSH) && (state_d == DONE);
  end

  // Datapath next values: scan chain, LFSR, MISR, counters and verdict.
  always_comb begin
    flops_d   = flops_q;
    lfsr_d    = lfsr_q;
    misr_d    = misr_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    pass_d    = pass_q;
    if (seed_en) begin
      lfsr_d    = SEED_EFF;
      misr_d    = '0;
      flops_d   = '0;
      cnt_d     = '0;
      bit_cnt_d = '0;
    end
    if (shift_en || flush_en) begin
      flops_d   = {si, flops_q[SCAN_LEN-1:1]};
      misr_d    = misr_step(misr_q) ^ {{(MISR_W-1){1'b0}}, so};
      bit_cnt_d = (bit_cnt_q == LAST_BIT) ? '0 : bit_cnt_q + BIT_CNT_W'(1);
    end
    if (shift_en || capture_en) lfsr_d = lfsr_step(lfsr_q);
    if (capture_en) begin
      flops_d   = core_nxt;
      misr_d    = misr_step(misr_q) ^ {{(MISR_W-2){1'b0}}, core_g17, 1'b0};
      cnt_d     = cnt_q + CNT_W'(1);
      bit_cnt_d = '0;
    end
    if (func_load) flops_d = core_nxt;
    if (seed_en || run_abort) pass_d = 1'b0;
    if (pass_load) pass_d = (misr_d == GOLDEN_SIG);
  end

  // Datapath and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flops_q   <= '0;
      lfsr_q    <= '0;
      misr_q    <= '0;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      flops_q   <= flops_d;
      lfsr_q    <= lfsr_d;
      misr_q    <= misr_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
    end
  end

  assign po          = core_g17;
  assign scan_state  = flops_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign signature   = misr_q;
  assign pattern_cnt = cnt_q;

endmodule
